// File: rtl/trigger_pkg.sv
// Shared types for the trigger family of storage blocks.
package trigger_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_CLR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_t;

endpackage

// File: rtl/trigger_d_stage_module.sv
// WIDTH-bit D trigger with enable and asynchronous active-high reset.
module trigger_d_stage_module #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/trigger_ushift_module.sv
// Universal shift register: DEPTH stages of WIDTH-bit D triggers with load,
// shift, rotate and clear, plus fill tracking and eviction output.
module trigger_ushift_module
  import trigger_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d_ser,
  input  logic [DEPTH*WIDTH-1:0]     d_par,
  output logic [DEPTH*WIDTH-1:0]     q_par,
  output logic [WIDTH-1:0]           q_hi,
  output logic [WIDTH-1:0]           q_lo,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full,
  output logic [WIDTH-1:0]           out_word,
  output logic                       out_valid
);

  localparam int FW = $clog2(DEPTH+1);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_d;
  logic [FW:0]      fill_inc;
  logic             evict;
  logic [WIDTH-1:0] evict_word;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      trigger_d_stage_module #(.WIDTH(WIDTH)) u_stage (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (stage_d[g]),
        .q   (stage_q[g])
      );
      assign q_par[g*WIDTH +: WIDTH] = stage_q[g];
    end
  endgenerate

  assign q_hi = stage_q[DEPTH-1];
  assign q_lo = stage_q[0];
  assign full = (fill_q == DEPTH_F);
  assign fill = fill_q;

  // Guard bit keeps the saturating increment from wrapping when DEPTH+1 is a power of two.
  assign fill_inc = {1'b0, fill_q} + (FW+1)'(1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      stage_d[i] = stage_q[i];
    fill_d     = fill_q;
    evict      = 1'b0;
    evict_word = stage_q[DEPTH-1];

    case (mode_t'(mode))
      MODE_LOAD: begin
        for (int i = 0; i < DEPTH; i++)
          stage_d[i] = d_par[i*WIDTH +: WIDTH];
        fill_d = DEPTH_F;
      end
      MODE_SHL: begin
        stage_d[0] = d_ser;
        for (int i = 1; i < DEPTH; i++)
          stage_d[i] = stage_q[i-1];
        evict      = full;
        evict_word = stage_q[DEPTH-1];
        fill_d     = (fill_inc >= (FW+1)'(DEPTH)) ? DEPTH_F : fill_inc[FW-1:0];
      end
      MODE_SHR: begin
        stage_d[DEPTH-1] = d_ser;
        for (int i = 0; i < DEPTH-1; i++)
          stage_d[i] = stage_q[i+1];
        evict      = full;
        evict_word = stage_q[0];
        fill_d     = (fill_inc >= (FW+1)'(DEPTH)) ? DEPTH_F : fill_inc[FW-1:0];
      end
      MODE_ROL: begin
        stage_d[0] = stage_q[DEPTH-1];
        for (int i = 1; i < DEPTH; i++)
          stage_d[i] = stage_q[i-1];
      end
      MODE_ROR: begin
        stage_d[DEPTH-1] = stage_q[0];
        for (int i = 0; i < DEPTH-1; i++)
          stage_d[i] = stage_q[i+1];
      end
      MODE_CLR: begin
        for (int i = 0; i < DEPTH; i++)
          stage_d[i] = '0;
        fill_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q    <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en && evict;
      if (en) begin
        fill_q <= fill_d;
        if (evict)
          out_word <= evict_word;
      end
    end
  end

endmodule
